partialsum_output_collector: RTL and testbench

PARTIALSUM_OUTPUT_COLLECTOR -- requirements
Module: partialsum_output_collector

---
 rtl/partialsum_output_collector.sv | 164 ++++++++++++++++
 tb/tb_partialsum_output_collector.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/partialsum_output_collector.sv
// partialsum_output_collector
// Takes the bottom-row outputs of a systolic array, re-aligns the 45-degree skew
// (or bypasses de-skew in test mode), and buffers complete rows in a
// first-word-fall-through FIFO with sticky overflow / skew error flags.
// Optional feature macro: PSUM_ROW_CNT_EN adds a 16-bit popped-row counter
// on output port rows_out_cnt.
module partialsum_output_collector #(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         test_mode,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]   partial_sum_in_flat,
    input  logic [SYSTOLIC_SIZE-1:0]                     partial_sum_valid_in,
    output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]   partial_sum_out_flat,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         fifo_full,
    output logic                                         overflow_err,
    output logic                                         skew_err,
    input  logic                                         err_clear
`ifdef PSUM_ROW_CNT_EN
    ,
    output logic [15:0]                                  rows_out_cnt
`endif
);

    // Handshake: a row leaves the FIFO on a rising edge where out_valid=1 and
    // out_ready=1; out_valid never depends on out_ready.

    localparam int N     = SYSTOLIC_SIZE;
    localparam int PW    = PARTIAL_SUM_WIDTH;
    localparam int ROW_W = N * PW;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic             test_mode_q;
    logic             mode_chg;
    logic [N-1:0]     al_valid;
    logic [ROW_W-1:0] al_data;

    // A mode change flushes in-flight skewed data and blocks this cycle's push.
    assign mode_chg = (test_mode != test_mode_q);

    // Previous-cycle test_mode, used to detect mode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) test_mode_q <= 1'b0;
        else        test_mode_q <= test_mode;
    end

    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int D = N - 1 - j;
        logic [PW-1:0] raw_data;
        logic          raw_valid;
        logic [PW-1:0] sk_data;
        logic          sk_valid;

        assign raw_data  = partial_sum_in_flat[j*PW +: PW];
        assign raw_valid = partial_sum_valid_in[j];

        if (D == 0) begin : g_pass
            assign sk_data  = raw_data;
            assign sk_valid = raw_valid;
        end else begin : g_dly
            logic [PW-1:0] dat_q [D];
            logic [D-1:0]  vld_q;

            // Column delay line: D stages so every column lines up with the last one.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) dat_q[k] <= '0;
                    vld_q <= '0;
                end else begin
                    dat_q[0] <= raw_data;
                    vld_q[0] <= raw_valid & ~mode_chg;
                    for (int k = 1; k < D; k++) begin
                        dat_q[k] <= dat_q[k-1];
                        vld_q[k] <= vld_q[k-1] & ~mode_chg;
                    end
                end
            end

            assign sk_data  = dat_q[D-1];
            assign sk_valid = vld_q[D-1];
        end

        assign al_data[j*PW +: PW] = test_mode ? raw_data  : sk_data;
        assign al_valid[j]         = test_mode ? raw_valid : sk_valid;
    end

    logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [ROW_W-1:0] last_q, last_d;
    logic             ovf_q, ovf_d;
    logic             skew_q, skew_d;
    logic             fifo_empty, full_w;
    logic             row_push, skew_evt, ovf_evt;
    logic             do_push, do_pop;
    logic [ROW_W-1:0] head;

    // Row qualification, FIFO pointer update and sticky error next-state.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        full_w     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head       = mem_q[rd_ptr_q[AW-1:0]];
        row_push   = (&al_valid) & ~mode_chg;
        skew_evt   = (|al_valid) & ~(&al_valid);
        do_pop     = ~fifo_empty & out_ready;
        do_push    = row_push & (~full_w | do_pop);
        ovf_evt    = row_push & full_w & ~do_pop;
        wr_ptr_d   = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        last_d     = do_pop  ? head : last_q;
        ovf_d      = (ovf_q  & ~err_clear) | ovf_evt;
        skew_d     = (skew_q & ~err_clear) | skew_evt;
    end

    // Control state: pointers, last-popped row and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
            skew_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            skew_q   <= skew_d;
        end
    end

    // Row storage; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= al_data;
    end

    assign out_valid            = ~fifo_empty;
    assign fifo_full            = full_w;
    assign overflow_err         = ovf_q;
    assign skew_err             = skew_q;
    assign partial_sum_out_flat = fifo_empty ? last_q : head;

`ifdef PSUM_ROW_CNT_EN
    logic [15:0] cnt_q;

    // Counts popped rows, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_q <= '0;
        else if (do_pop) cnt_q <= cnt_q + 16'd1;
    end

    assign rows_out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_partialsum_output_collector.sv
// Testbench for partialsum_output_collector (default parameters).
module tb_partialsum_output_collector;

    localparam int N     = 8;
    localparam int PW    = 19;
    localparam int ROW_W = N * PW;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             test_mode = 1'b0;
    logic [ROW_W-1:0] partial_sum_in_flat = '0;
    logic [N-1:0]     partial_sum_valid_in = '0;
    logic [ROW_W-1:0] partial_sum_out_flat;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             fifo_full;
    logic             overflow_err;
    logic             skew_err;
    logic             err_clear = 1'b0;
`ifdef PSUM_ROW_CNT_EN
    logic [15:0]      rows_out_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    partialsum_output_collector dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .test_mode            (test_mode),
        .partial_sum_in_flat  (partial_sum_in_flat),
        .partial_sum_valid_in (partial_sum_valid_in),
        .partial_sum_out_flat (partial_sum_out_flat),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .fifo_full            (fifo_full),
        .overflow_err         (overflow_err),
        .skew_err             (skew_err),
        .err_clear            (err_clear)
`ifdef PSUM_ROW_CNT_EN
        ,
        .rows_out_cnt         (rows_out_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] fill(input int val);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) r[j*PW +: PW] = PW'(val);
        return r;
    endfunction

    // ---------------- behavioural model / scoreboard ----------------
    // Column j in normal mode shows the input seen N-1-j cycles earlier, unless
    // that input was captured on or before the last flush (reset or mode change).
    logic [ROW_W-1:0] exp_q[$];
    logic [ROW_W-1:0] hist_d [32];
    logic [N-1:0]     hist_v [32];
    logic [ROW_W-1:0] m_last;
    logic             m_ovf, m_skew, m_tm;
    logic [15:0]      m_cnt;
    int               m_clear = 0;
    int               cyc = 0;

    task automatic check_outputs();
        int sz;
        sz = exp_q.size();
        chk("m_out_valid", ROW_W'(out_valid), ROW_W'(sz > 0));
        chk("m_fifo_full", ROW_W'(fifo_full), ROW_W'(sz == DEPTH));
        chk("m_overflow",  ROW_W'(overflow_err), ROW_W'(m_ovf));
        chk("m_skew",      ROW_W'(skew_err), ROW_W'(m_skew));
        chk("m_row",       partial_sum_out_flat, (sz > 0) ? exp_q[0] : m_last);
`ifdef PSUM_ROW_CNT_EN
        chk("m_cnt",       ROW_W'(rows_out_cnt), ROW_W'(m_cnt));
`endif
    endtask

    task automatic step_model();
        logic [N-1:0]     av;
        logic [ROW_W-1:0] ad, tmp;
        logic             mc, push, mixed, full, pop, ovf_evt;
        av = '0;
        ad = '0;
        mc = (test_mode !== m_tm);
        if (test_mode) begin
            av = partial_sum_valid_in;
            ad = partial_sum_in_flat;
        end else begin
            for (int j = 0; j < N; j++) begin
                int dl, s;
                dl = N - 1 - j;
                s  = cyc - dl;
                if (dl > 0 && s <= m_clear) begin
                    av[j] = 1'b0;
                end else begin
                    tmp = hist_d[s % 32];
                    av[j] = hist_v[s % 32][j];
                    ad[j*PW +: PW] = tmp[j*PW +: PW];
                end
            end
        end
        push    = (&av) && !mc;
        mixed   = (|av) && !(&av);
        full    = (exp_q.size() == DEPTH);
        pop     = (exp_q.size() > 0) && out_ready;
        ovf_evt = push && full && !pop;
        if (pop) begin
            m_last = exp_q.pop_front();
            m_cnt  = m_cnt + 16'd1;
        end
        if (push && !ovf_evt) exp_q.push_back(ad);
        m_ovf  = (m_ovf  && !err_clear) || ovf_evt;
        m_skew = (m_skew && !err_clear) || mixed;
        if (mc) m_clear = cyc;
        m_tm = test_mode;
    endtask

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        hist_d[cyc % 32] = partial_sum_in_flat;
        hist_v[cyc % 32] = partial_sum_valid_in;
        if (!rst_n) begin
            exp_q.delete();
            m_last  = '0;
            m_ovf   = 1'b0;
            m_skew  = 1'b0;
            m_tm    = 1'b0;
            m_cnt   = '0;
            m_clear = cyc;
            check_outputs();
        end else begin
            check_outputs();
            step_model();
        end
        cyc++;
    end

    // ---------------- driver ----------------
    task automatic drive(input logic tm, input logic [N-1:0] v, input logic [ROW_W-1:0] d,
                         input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        test_mode            = tm;
        partial_sum_valid_in = v;
        partial_sum_in_flat  = d;
        out_ready            = rdy;
        err_clear            = clr;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [ROW_W-1:0] row;
        logic [ROW_W-1:0] lit;
        int               exp22 [4];
        bit               start_h [16];
        int               rc, seg_left, rdy_pct;
        logic             tm_r;
        logic [N-1:0]     v;

        exp22 = '{2, 3, 4, 9};

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_out_valid", ROW_W'(out_valid), '0);
        chk("rst_fifo_full", ROW_W'(fifo_full), '0);
        chk("rst_ovf",       ROW_W'(overflow_err), '0);
        chk("rst_skew",      ROW_W'(skew_err), '0);
        chk("rst_row",       partial_sum_out_flat, '0);
        drive(0, '0, '0, 1, 0);
        rst_n = 1'b1;
        drive(0, '0, '0, 1, 0);
        drive(0, '0, '0, 1, 0);

        // Skewed row, column j = 100+j arriving at cycle t+j
        lit = '0;
        for (int j = 0; j < N; j++) lit[j*PW +: PW] = PW'(100 + j);
        for (int k = 0; k < N; k++) begin
            row = '0;
            row[k*PW +: PW] = PW'(100 + k);
            drive(0, N'(1) << k, row, 1, 0);
        end
        #2 chk("skew_row_early", ROW_W'(out_valid), '0);
        drive(0, '0, '0, 1, 0);
        #2 chk("skew_row_valid", ROW_W'(out_valid), ROW_W'(1));
        chk("skew_row_data", partial_sum_out_flat, lit);
        chk("skew_row_noerr", ROW_W'({overflow_err, skew_err}), '0);
        drive(0, '0, '0, 1, 0);
        #2 chk("skew_row_once", ROW_W'(out_valid), '0);

        // Test mode: one-cycle latency
        drive(1, '0, '0, 1, 0);
        drive(1, '0, '0, 1, 0);
        drive(1, '1, fill(32'h5A), 1, 0);
        #2 chk("tm_early", ROW_W'(out_valid), '0);
        drive(1, '0, '0, 1, 0);
        #2 chk("tm_valid", ROW_W'(out_valid), ROW_W'(1));
        chk("tm_data", partial_sum_out_flat, fill(32'h5A));
        drive(1, '0, '0, 1, 0);

        // Overflow: five rows into a four-deep FIFO
        for (int k = 1; k <= 5; k++) drive(1, '1, fill(k), 0, 0);
        #2 chk("ovf_full", ROW_W'(fifo_full), ROW_W'(1));
        chk("ovf_not_yet", ROW_W'(overflow_err), '0);
        drive(1, '0, '0, 0, 0);
        #2 chk("ovf_set", ROW_W'(overflow_err), ROW_W'(1));
        for (int k = 1; k <= 4; k++) begin
            drive(1, '0, '0, 1, 0);
            #2 chk("ovf_pop_data", partial_sum_out_flat, fill(k));
        end
        drive(1, '0, '0, 1, 0);
        #2 chk("ovf_empty", ROW_W'(out_valid), '0);
        chk("ovf_last_popped", partial_sum_out_flat, fill(4));
        drive(1, '0, '0, 1, 1);
        drive(1, '0, '0, 1, 0);
        #2 chk("ovf_cleared", ROW_W'(overflow_err), '0);

        // Push and pop together at full
        for (int k = 1; k <= 4; k++) drive(1, '1, fill(k), 0, 0);
        drive(1, '1, fill(9), 1, 0);
        drive(1, '0, '0, 0, 0);
        #2 chk("pp_full", ROW_W'(fifo_full), ROW_W'(1));
        chk("pp_noovf", ROW_W'(overflow_err), '0);
        for (int k = 0; k < 4; k++) begin
            drive(1, '0, '0, 1, 0);
            #2 chk("pp_data", partial_sum_out_flat, fill(exp22[k]));
        end
        drive(1, '0, '0, 1, 0);

        // Skew error, clear, and clear colliding with a new error
        drive(1, 8'h0F, fill(3), 1, 0);
        drive(1, '0, '0, 1, 0);
        #2 chk("skew_set", ROW_W'(skew_err), ROW_W'(1));
        chk("skew_nopush", ROW_W'(out_valid), '0);
        drive(1, '0, '0, 1, 1);
        drive(1, '0, '0, 1, 0);
        #2 chk("skew_clr", ROW_W'(skew_err), '0);
        drive(1, 8'hF0, fill(1), 1, 1);
        drive(1, '0, '0, 1, 0);
        #2 chk("skew_win", ROW_W'(skew_err), ROW_W'(1));
        drive(1, '0, '0, 1, 1);
        drive(1, '0, '0, 1, 0);

        // Reset in the middle of a skewed row with rows buffered
        drive(1, '1, fill(7), 0, 0);
        drive(1, '1, fill(8), 0, 0);
        drive(0, '0, '0, 0, 0);
        drive(0, '0, '0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            row = '0;
            row[k*PW +: PW] = PW'(200 + k);
            drive(0, N'(1) << k, row, 0, 0);
        end
        #2 chk("mid_pre_valid", ROW_W'(out_valid), ROW_W'(1));
        rst_n = 1'b0;
        #1 chk("mid_rst_valid", ROW_W'(out_valid), '0);
        chk("mid_rst_row", partial_sum_out_flat, '0);
        chk("mid_rst_full", ROW_W'(fifo_full), '0);
`ifdef PSUM_ROW_CNT_EN
        chk("mid_rst_cnt", ROW_W'(rows_out_cnt), '0);
`endif
        partial_sum_valid_in = '0;
        drive(0, '0, '0, 1, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(0, '0, '0, 1, 0);
            #2 chk("post_rst_idle", ROW_W'(out_valid), '0);
        end

        // Randomized traffic against the model
        seg_left = 0;
        rc = 0;
        tm_r = 1'b0;
        rdy_pct = 50;
        for (int i = 0; i < 16; i++) start_h[i] = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            if (seg_left == 0) begin
                tm_r     = 1'($urandom_range(0, 1));
                seg_left = $urandom_range(20, 60);
                rdy_pct  = $urandom_range(20, 95);
                rc       = 0;
                for (int i = 0; i < 16; i++) start_h[i] = 1'b0;
            end
            seg_left--;
            row = '0;
            for (int j = 0; j < N; j++) row[j*PW +: PW] = PW'($urandom);
            if (tm_r) begin
                v = ($urandom_range(0, 1) == 1) ? '1 : '0;
                if ($urandom_range(0, 29) == 0) v = N'($urandom);
            end else begin
                start_h[rc % 16] = ($urandom_range(0, 2) == 0);
                v = '0;
                for (int j = 0; j < N; j++)
                    if (rc - j >= 0) v[j] = start_h[(rc - j) % 16];
                if ($urandom_range(0, 49) == 0) v[$urandom_range(0, N-1)] ^= 1'b1;
                rc++;
            end
            drive(tm_r, v, row, ($urandom_range(1, 100) <= rdy_pct), ($urandom_range(0, 19) == 0));
        end
        drive(0, '0, '0, 1, 0);
        drive(0, '0, '0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
